axi4_lite_gpu_execute_rect: RTL and testbench
=============================================

Name: axi4_lite_gpu_execute_rect

Overview:
Rectangle-fill execution unit of the AXI4-Lite GPU. It captures two corner points and a colour from the command decoder. On start it writes that colour to every pixel of the inclusive rectangle in the framebuffer, one pixel per clock. It sits between the register/command front end and the framebuffer BRAM write port.

Parameters:
FRAME_WIDTH_SCALED, 640, frame width in pixels; row stride of the framebuffer
FRAME_HEIGHT_SCALED, 480, frame height in pixels
COLOR_WIDTH, 8, width of the colour operand
FBUF_ADDR_WIDTH, 19, framebuffer address width
FBUF_DATA_WIDTH, 8, framebuffer data width

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-high (1 = reset) despite the codebase name
start  in  1  one-cycle command strobe
busy  out  1  high while the rectangle is being filled
done  out  1  one-cycle pulse at command end (success or error)
err  out  1  one-cycle pulse with done when the command is rejected
left_valid  in  1  strobe: capture left_x/left_y
left_x  in  12  top-left corner x
left_y  in  12  top-left corner y
right_valid  in  1  strobe: capture right_x/right_y
right_x  in  12  bottom-right corner x, inclusive
right_y  in  12  bottom-right corner y, inclusive
color_valid  in  1  strobe: capture color
color  in  COLOR_WIDTH  fill colour
fbuf_en_wr  out  1  framebuffer port enable
fbuf_wrea  out  1  framebuffer write enable
fbuf_addr  out  FBUF_ADDR_WIDTH  pixel address
fbuf_data  out  FBUF_DATA_WIDTH  pixel data

Behaviour:
- Reset: state IDLE; busy, done, err, fbuf_en_wr and fbuf_wrea are 0; fbuf_addr and fbuf_data are 0; staged operands and their have-flags are cleared.
- Staging:
  - Any cycle with left_valid, right_valid or color_valid high loads the matching staging register and sets its have-flag. This includes cycles while busy.
  - Staged values affect only the next accepted command.
- IDLE, start=1 (start is ignored when not in IDLE):
  - Snapshot the staging registers into working registers.
  - Clear all three have-flags.
  - Validate the command. It is rejected if any of these holds:
    - any have-flag is clear;
    - left_x > right_x, or left_y > right_y;
    - right_x >= FRAME_WIDTH_SCALED, or right_y >= FRAME_HEIGHT_SCALED.
  - Rejected: go to DONE with err pending. No framebuffer writes are issued.
  - Accepted: go to FILL with x=left_x and y=left_y.
- FILL, one pixel per cycle:
  - busy=1, fbuf_en_wr=1, fbuf_wrea=1.
  - fbuf_addr = y*FRAME_WIDTH_SCALED + x, computed at full precision and truncated to FBUF_ADDR_WIDTH.
  - fbuf_data = color, zero-extended or truncated to FBUF_DATA_WIDTH.
  - Scan order is raster: x increments. When x==right_x, x returns to left_x and y increments.
  - After the write at (right_x, right_y), go to DONE.
- DONE (exactly one cycle): done=1; err=1 only for a rejected command; busy=0; write enables 0. Then return to IDLE.
- Latency:
  - All outputs are registered.
  - First write is visible on the cycle after start is sampled.
  - N = (right_x-left_x+1)*(right_y-left_y+1) write cycles.
  - done follows the last write cycle.
- A 1x1 rectangle (left equals right) produces a single write.
- Reset mid-operation aborts immediately to the reset state with no further writes.
- Outside FILL, fbuf_en_wr and fbuf_wrea are 0; fbuf_addr and fbuf_data hold their last values.

Test Plan:
- Basic fill: stage left (0,1), right (9,10), color 0xE0, then pulse start.
  - Required: busy rises the next cycle, then 100 consecutive writes of data 0xE0.
  - Addresses run 640..649, 1280..1289, up to 6400..6409.
  - done pulses once with err=0; busy is then 0.
- Single pixel: left = right = (639,479), color 0x1F -> exactly one write at address 307199, then done.
- Missing operand: stage only left and right, omit color, pulse start -> done=1 and err=1 for one cycle, no write enable ever asserted.
- Inverted or out-of-range corners:
  - left (5,0), right (4,0) -> err with no writes.
  - right_x=640 -> err with no writes.
- Start while busy: pulse start again during a fill -> ignored; write count is unchanged and only one done pulse occurs.
- Reset mid-fill: assert rst_n=1 partway through a fill -> writes stop the next cycle; all outputs are 0 and have-flags cleared, so a following start gives err.

Source files
------------

// File: rtl/axi4_lite_gpu_execute_rect.sv
// rtl/axi4_lite_gpu_execute_rect.sv - rectangle-fill execution unit writing one pixel per clock
//
// Captures two inclusive corner points and a fill colour from the command
// decoder, then on start paints every pixel of the rectangle into the
// framebuffer BRAM write port in raster order.
//
// Ports:
//   clk, rst_n        clock and synchronous reset (rst_n is active-HIGH)
//   start             one-cycle command strobe, honoured only when idle
//   busy, done, err   status: busy during fill, done pulse at end, err with done on reject
//   left_*/right_*    corner staging strobes and coordinates (right corner inclusive)
//   color_valid/color fill colour staging strobe and value
//   fbuf_*            framebuffer write port (enable, write enable, address, data)
`timescale 1ns/1ps

module axi4_lite_gpu_execute_rect #(
  parameter int FRAME_WIDTH_SCALED  = 640,
  parameter int FRAME_HEIGHT_SCALED = 480,
  parameter int COLOR_WIDTH         = 8,
  parameter int FBUF_ADDR_WIDTH     = 19,
  parameter int FBUF_DATA_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       left_valid,
  input  logic [11:0]                left_x,
  input  logic [11:0]                left_y,
  input  logic                       right_valid,
  input  logic [11:0]                right_x,
  input  logic [11:0]                right_y,
  input  logic                       color_valid,
  input  logic [COLOR_WIDTH-1:0]     color,
  output logic                       fbuf_en_wr,
  output logic                       fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);

  localparam logic [31:0] STRIDE = FRAME_WIDTH_SCALED;
  localparam logic [31:0] HEIGHT = FRAME_HEIGHT_SCALED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // Staging registers, written by the decoder strobes at any time.
  logic [11:0]            stg_lx, stg_ly, stg_rx, stg_ry;
  logic [COLOR_WIDTH-1:0] stg_color;
  logic                   have_left, have_right, have_color;

  // Working copy of the accepted command. The top edge is only needed at
  // accept time, so no working copy of left_y is kept.
  logic [11:0]            wrk_lx, wrk_rx, wrk_ry;
  logic [COLOR_WIDTH-1:0] wrk_color;

  // Coordinate of the pixel currently presented on the write port.
  logic [11:0] cur_x, cur_y;
  logic [11:0] x_next, y_next;

  logic                       take_cmd;
  logic                       cmd_ok;
  logic                       emit;
  logic [COLOR_WIDTH-1:0]     emit_color;
  logic [31:0]                pix_full;
  logic                       busy_next, done_next, err_next, wr_next;
  logic [FBUF_ADDR_WIDTH-1:0] addr_next;
  logic [FBUF_DATA_WIDTH-1:0] data_next;

  function automatic logic [FBUF_DATA_WIDTH-1:0] fit_color(input logic [COLOR_WIDTH-1:0] c);
    logic [63:0] wide;
    wide = 64'(c);
    return wide[FBUF_DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    cmd_ok = have_left && have_right && have_color &&
             (stg_lx <= stg_rx) && (stg_ly <= stg_ry) &&
             ({20'd0, stg_rx} < STRIDE) && ({20'd0, stg_ry} < HEIGHT);
  end

  always_comb begin
    state_next = state;
    x_next     = cur_x;
    y_next     = cur_y;
    take_cmd   = 1'b0;
    emit       = 1'b0;
    emit_color = wrk_color;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    wr_next    = 1'b0;
    addr_next  = fbuf_addr;
    data_next  = fbuf_data;

    case (state)
      S_IDLE: begin
        if (start) begin
          take_cmd = 1'b1;
          if (cmd_ok) begin
            // Present the first pixel straight from the staging registers so
            // it appears on the cycle after start.
            state_next = S_FILL;
            x_next     = stg_lx;
            y_next     = stg_ly;
            emit       = 1'b1;
            emit_color = stg_color;
          end else begin
            state_next = S_DONE;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (cur_x == wrk_rx && cur_y == wrk_ry) begin
          state_next = S_DONE;
          done_next  = 1'b1;
        end else begin
          emit = 1'b1;
          if (cur_x == wrk_rx) begin
            x_next = wrk_lx;
            y_next = cur_y + 12'd1;
          end else begin
            x_next = cur_x + 12'd1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    pix_full = {20'd0, y_next} * STRIDE + {20'd0, x_next};
    if (emit) begin
      busy_next = 1'b1;
      wr_next   = 1'b1;
      addr_next = pix_full[FBUF_ADDR_WIDTH-1:0];
      data_next = fit_color(emit_color);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      stg_lx     <= '0;
      stg_ly     <= '0;
      stg_rx     <= '0;
      stg_ry     <= '0;
      stg_color  <= '0;
      have_left  <= 1'b0;
      have_right <= 1'b0;
      have_color <= 1'b0;
      wrk_lx     <= '0;
      wrk_rx     <= '0;
      wrk_ry     <= '0;
      wrk_color  <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      fbuf_en_wr <= 1'b0;
      fbuf_wrea  <= 1'b0;
      fbuf_addr  <= '0;
      fbuf_data  <= '0;
    end else begin
      cur_x      <= x_next;
      cur_y      <= y_next;
      busy       <= busy_next;
      done       <= done_next;
      err        <= err_next;
      fbuf_en_wr <= wr_next;
      fbuf_wrea  <= wr_next;
      fbuf_addr  <= addr_next;
      fbuf_data  <= data_next;

      if (take_cmd) begin
        wrk_lx     <= stg_lx;
        wrk_rx     <= stg_rx;
        wrk_ry     <= stg_ry;
        wrk_color  <= stg_color;
        have_left  <= 1'b0;
        have_right <= 1'b0;
        have_color <= 1'b0;
      end

      // A strobe coinciding with an accepted start belongs to the next
      // command, so it wins over the flag clear above.
      if (left_valid) begin
        stg_lx    <= left_x;
        stg_ly    <= left_y;
        have_left <= 1'b1;
      end
      if (right_valid) begin
        stg_rx     <= right_x;
        stg_ry     <= right_y;
        have_right <= 1'b1;
      end
      if (color_valid) begin
        stg_color  <= color;
        have_color <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_gpu_execute_rect.sv
// tb/tb_axi4_lite_gpu_execute_rect.sv - self-checking bench for the rectangle-fill unit
`timescale 1ns/1ps

module tb_axi4_lite_gpu_execute_rect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, err;
  logic        left_valid, right_valid, color_valid;
  logic [11:0] left_x, left_y, right_x, right_y;
  logic [7:0]  color;
  logic        fbuf_en_wr, fbuf_wrea;
  logic [18:0] fbuf_addr;
  logic [7:0]  fbuf_data;

  axi4_lite_gpu_execute_rect dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .left_valid (left_valid),
    .left_x     (left_x),
    .left_y     (left_y),
    .right_valid(right_valid),
    .right_x    (right_x),
    .right_y    (right_y),
    .color_valid(color_valid),
    .color      (color),
    .fbuf_en_wr (fbuf_en_wr),
    .fbuf_wrea  (fbuf_wrea),
    .fbuf_addr  (fbuf_addr),
    .fbuf_data  (fbuf_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Monitor: everything observed on falling edges.
  int          cyc = 0;
  logic [26:0] wq[$];
  int          wcyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;
  int          wrea_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (fbuf_en_wr === 1'b1) begin
      wq.push_back({fbuf_addr, fbuf_data});
      wcyc.push_back(cyc);
    end
    if (fbuf_wrea !== fbuf_en_wr) wrea_bad++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end
  end

  // Reference model of the staging registers.
  int m_lx, m_ly, m_rx, m_ry, m_col;
  bit m_hl, m_hr, m_hc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stage_left(input int x, input int y);
    @(negedge clk);
    left_valid = 1'b1; left_x = 12'(x); left_y = 12'(y);
    @(negedge clk);
    left_valid = 1'b0;
    m_lx = x & 'hFFF; m_ly = y & 'hFFF; m_hl = 1;
  endtask

  task automatic stage_right(input int x, input int y);
    @(negedge clk);
    right_valid = 1'b1; right_x = 12'(x); right_y = 12'(y);
    @(negedge clk);
    right_valid = 1'b0;
    m_rx = x & 'hFFF; m_ry = y & 'hFFF; m_hr = 1;
  endtask

  task automatic stage_color(input int c);
    @(negedge clk);
    color_valid = 1'b1; color = 8'(c);
    @(negedge clk);
    color_valid = 1'b0;
    m_col = c & 'hFF; m_hc = 1;
  endtask

  // Issues start and checks the whole command against the model. restart_at
  // pulses start again that many cycles into the command (negative: never);
  // stage_during loads a fresh random valid command while the fill runs.
  task automatic fire(input string tag, input int restart_at, input bit stage_during);
    logic [26:0] eq[$];
    bit ok;
    int sc, cycles, mism, n;
    int nlx, nly, nrx, nry, ncol;
    ok = m_hl && m_hr && m_hc && (m_lx <= m_rx) && (m_ly <= m_ry) &&
         (m_rx < 640) && (m_ry < 480);
    if (ok)
      for (int y = m_ly; y <= m_ry; y++)
        for (int x = m_lx; x <= m_rx; x++)
          eq.push_back({19'(y * 640 + x), 8'(m_col)});
    m_hl = 0; m_hr = 0; m_hc = 0;
    wq.delete(); wcyc.delete(); done_cnt = 0; wrea_bad = 0;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    sc = cyc;
    check({tag, ".busy_after_start"}, 64'(busy), 64'(ok));
    check({tag, ".first_write"}, 64'(fbuf_en_wr), 64'(ok));

    nlx = $urandom_range(0, 600); nly = $urandom_range(0, 400);
    nrx = nlx + $urandom_range(0, 7); nry = nly + $urandom_range(0, 4);
    ncol = $urandom_range(0, 255);
    cycles = 0;
    while (done_cnt == 0 && cycles < 3000) begin
      start = (cycles == restart_at);
      if (stage_during && cycles == 2) begin
        left_valid = 1'b1; left_x = 12'(nlx); left_y = 12'(nly);
        right_valid = 1'b1; right_x = 12'(nrx); right_y = 12'(nry);
        color_valid = 1'b1; color = 8'(ncol);
        m_lx = nlx; m_ly = nly; m_rx = nrx; m_ry = nry; m_col = ncol;
        m_hl = 1; m_hr = 1; m_hc = 1;
      end else begin
        left_valid = 1'b0; right_valid = 1'b0; color_valid = 1'b0;
      end
      @(negedge clk); #1;
      cycles++;
    end
    start = 1'b0; left_valid = 1'b0; right_valid = 1'b0; color_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    check({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, ".err"}, 64'(done_err), 64'(!ok));
    check({tag, ".done_cycle"}, 64'(done_cyc - sc), 64'(eq.size()));
    check({tag, ".write_count"}, 64'(wq.size()), 64'(eq.size()));
    mism = 0;
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int k = 0; k < n; k++)
      if (wq[k] !== eq[k] || wcyc[k] != sc + k) mism++;
    check({tag, ".pixel_mismatches"}, 64'(mism), 64'd0);
    check({tag, ".busy_after_done"}, 64'(busy), 64'd0);
    check({tag, ".wrea_tracks_en"}, 64'(wrea_bad), 64'd0);
  endtask

  initial begin
    int lx, ly, rx, ry, nwr;
    rst_n = 1'b1; start = 1'b0;
    left_valid = 1'b0; right_valid = 1'b0; color_valid = 1'b0;
    left_x = '0; left_y = '0; right_x = '0; right_y = '0; color = '0;
    m_hl = 0; m_hr = 0; m_hc = 0;
    m_lx = 0; m_ly = 0; m_rx = 0; m_ry = 0; m_col = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.err", 64'(err), 64'd0);
    check("reset.en_wr", 64'(fbuf_en_wr), 64'd0);
    check("reset.wrea", 64'(fbuf_wrea), 64'd0);
    check("reset.addr", 64'(fbuf_addr), 64'd0);
    check("reset.data", 64'(fbuf_data), 64'd0);
    rst_n = 1'b0;

    stage_left(0, 1); stage_right(9, 10); stage_color('hE0);
    fire("basic", -1, 0);

    stage_left(639, 479); stage_right(639, 479); stage_color('h1F);
    fire("single", -1, 0);

    stage_left(2, 3); stage_right(4, 5);
    fire("missing_color", -1, 0);

    stage_left(5, 0); stage_right(4, 0); stage_color('h33);
    fire("inverted_x", -1, 0);

    stage_left(600, 0); stage_right(640, 2); stage_color('h44);
    fire("right_x_640", -1, 0);

    stage_left(0, 470); stage_right(3, 480); stage_color('h55);
    fire("right_y_480", -1, 0);

    stage_left(0, 0); stage_right(9, 9); stage_color('hAA);
    fire("start_while_busy", 5, 1);
    fire("staged_while_busy", -1, 0);

    for (int i = 0; i < 10; i++) begin
      lx = $urandom_range(0, 645);
      ly = $urandom_range(0, 485);
      rx = ($urandom_range(0, 7) == 0) ? lx - 1 : lx + $urandom_range(0, 8);
      ry = ($urandom_range(0, 7) == 0) ? ly - 1 : ly + $urandom_range(0, 4);
      stage_left(lx, ly);
      stage_right(rx & 'hFFF, ry & 'hFFF);
      if ($urandom_range(0, 7) != 0) stage_color($urandom_range(0, 255));
      fire($sformatf("rand%0d", i), -1, 0);
    end

    stage_left(0, 0); stage_right(20, 3); stage_color('h77);
    wq.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    m_hl = 0; m_hr = 0; m_hc = 0;
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.en_wr", 64'(fbuf_en_wr), 64'd0);
    check("midreset.addr", 64'(fbuf_addr), 64'd0);
    check("midreset.data", 64'(fbuf_data), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    nwr = wq.size();
    repeat (3) @(negedge clk);
    #1;
    check("midreset.writes_stopped", 64'(wq.size()), 64'(nwr));
    rst_n = 1'b0;
    fire("after_reset", -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
